// File: rtl/dbus_init_pkg.sv
// dbus_init_pkg: state encoding, defaults and byte-lane legality for dbus_initiator.
package dbus_init_pkg;

   typedef enum logic [1:0] {IDLE, REQ, RESP} type_dbus_init_state_e;

   localparam int DBUS_INIT_TIMEOUT_DEFAULT = 255;

   function automatic logic is_legal_sel_byte(input logic [3:0] sel);
      return sel inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
   endfunction

endpackage

// File: rtl/peri_defs_pkg.sv
// peri_defs_pkg: peripheral-side data bus structs shared by initiators and responders.
package peri_defs_pkg;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] w_data;
      logic        w_en;
      logic        req;
      logic [3:0]  sel_byte;
   } type_dbus2peri_s;

   typedef struct packed {
      logic [31:0] r_data;
      logic        ack;
   } type_peri2dbus_s;

endpackage

// File: rtl/dbus_initiator.sv
// dbus_initiator: issues one data-bus transaction per command and returns data or error,
// aborting with error if the peripheral never acknowledges.
module dbus_initiator
   import dbus_init_pkg::*, peri_defs_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DBUS_INIT_TIMEOUT_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cmd_valid_i,
   output logic            cmd_ready_o,
   input  logic [31:0]     cmd_addr_i,
   input  logic [31:0]     cmd_wdata_i,
   input  logic            cmd_we_i,
   input  logic [3:0]      cmd_sel_byte_i,
   output logic            rsp_valid_o,
   input  logic            rsp_ready_i,
   output logic [31:0]     rsp_rdata_o,
   output logic            rsp_err_o,
   output type_dbus2peri_s dbus2peri_o,
   input  type_peri2dbus_s peri2dbus_i,
   output logic            busy_o
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   type_dbus_init_state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   addr_q, wdata_q, rdata_q, rdata_d;
   logic [3:0]    sel_q;
   logic          we_q, err_q, err_d;
   logic          accept, legal, ack, tout;

   assign accept = cmd_valid_i && state_q == IDLE;
   assign legal  = is_legal_sel_byte(cmd_sel_byte_i);
   assign ack    = state_q == REQ && peri2dbus_i.ack;
   assign tout   = state_q == REQ && cnt_q == CW'(TIMEOUT_CYCLES - 1);

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cmd_valid_i) state_d = legal ? REQ : RESP;
         REQ:     if (ack || tout) state_d = RESP;
         RESP:    if (rsp_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready_o = rst_n && state_q == IDLE;
      rsp_valid_o = state_q == RESP;
      busy_o      = state_q != IDLE;
      rsp_rdata_o = rdata_q;
      rsp_err_o   = err_q;
      dbus2peri_o = '{addr: addr_q, w_data: wdata_q, w_en: we_q, req: state_q == REQ, sel_byte: sel_q};
   end

   // Ack wins over a timeout landing in the same cycle; the counter saturates rather than wraps.
   always_comb begin
      cnt_d   = state_q == REQ ? ((&cnt_q) ? cnt_q : cnt_q + 1'b1) : '0;
      rdata_d = rdata_q;
      err_d   = err_q;
      if (accept) begin
         rdata_d = '0;
         err_d   = !legal;
      end else if (ack) begin
         rdata_d = we_q ? '0 : peri2dbus_i.r_data;
         err_d   = 1'b0;
      end else if (tout) begin
         rdata_d = '0;
         err_d   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         sel_q   <= '0;
      end else begin
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         if (accept) begin
            addr_q  <= cmd_addr_i;
            wdata_q <= cmd_wdata_i;
            we_q    <= cmd_we_i;
            sel_q   <= cmd_sel_byte_i;
         end
      end
   end

endmodule

// File: doc/dbus_initiator.md
# dbus_initiator

Data-bus initiator: accepts single read/write commands on a valid/ready command port, drives one `type_dbus2peri_s` transaction to a peripheral (GPIO, switch/LED, timer, …), waits for the peripheral's one-cycle `ack`, and returns read data or an error on a valid/ready response port. It sits between a command source (debug/UART bridge, test sequencer) and the peripheral side of the data bus. A timeout guards against peripherals that never acknowledge.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles `req` may stay high without `ack` before the transaction aborts with error; legal range is 1..65535.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cmd_valid_i`  in  1  command present.
- `cmd_ready_o`  out  1  command accepted when high together with `cmd_valid_i`.
- `cmd_addr_i`  in  32  byte address.
- `cmd_wdata_i`  in  32  write data.
- `cmd_we_i`  in  1  1 = write, 0 = read.
- `cmd_sel_byte_i`  in  4  byte lanes.
- `rsp_valid_o`  out  1  response present.
- `rsp_ready_i`  in  1  response consumed.
- `rsp_rdata_o`  out  32  read data; 0 for writes and errors.
- `rsp_err_o`  out  1  timeout or illegal `sel_byte`.
- `dbus2peri_o`  out  `type_dbus2peri_s`  carries `addr`, `w_data`, `w_en`, `req`, `sel_byte`.
- `peri2dbus_i`  in  `type_peri2dbus_s`  carries `r_data`, `ack`.
- `busy_o`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE
  - `cmd_ready_o`=1.
  - On `cmd_valid_i`, latch addr, wdata, we and sel_byte.
  - Legal sel_byte values are 0001, 0010, 0100, 1000, 0011, 1100, 1111. With a legal value, go to REQ.
  - With an illegal value, go straight to RESP with err=1 and rdata=0. No bus cycle is issued.
- REQ
  - `req`=1 with the latched fields; `w_en`=we.
  - Timeout counter starts at 0 on entry and increments each REQ cycle without `ack`.
  - On `ack`=1: capture `r_data` if read, otherwise 0. Set err=0 and go to RESP.
  - If the counter reaches `TIMEOUT_CYCLES - 1` with no `ack`: rdata=0, err=1, go to RESP.
- RESP
  - `rsp_valid_o`=1; rdata and err are held stable.
  - When `rsp_ready_i`=1, go to IDLE.
- The response is never dropped or changed while `rsp_valid_o`=1 and `rsp_ready_i`=0.
- `ack` is ignored in IDLE and RESP, including a late ack after a timeout.
- `dbus2peri_o` fields other than `req` are held at their latched values from REQ entry until the next command. In IDLE after reset they are 0.
- Counter width is `$clog2(TIMEOUT_CYCLES+1)`. The counter saturates and never wraps.

## Timing
- Reset values: `cmd_ready_o`=0 during reset and 1 on the first cycle after reset in IDLE. `rsp_valid_o`=0, `rsp_rdata_o`=0, `rsp_err_o`=0, `busy_o`=0, all `dbus2peri_o` fields=0.
- All outputs are registered or decoded from state; there is no combinational path from `peri2dbus_i` to `dbus2peri_o`.
- Cycle numbering:
  - Accept at edge 0.
  - `req` is high in cycle 1.
  - If the peripheral acks in cycle 2, `req` is low and `rsp_valid_o` is high in cycle 3.
- Minimum command-to-response latency is 3 cycles. With `rsp_ready_i` tied to 1, back-to-back throughput is one command per 4 cycles.
- `req` stays high during the `ack` cycle. Responders gate re-ack on their own registered ack, so no duplicate transaction occurs. `req` must fall on the edge that samples `ack`.
- Illegal sel_byte: `rsp_valid_o` rises the cycle after accept and `req` never pulses.
- Timeout: `req` is high for exactly `TIMEOUT_CYCLES` cycles, then `rsp_valid_o` rises the next cycle.
- Reset asserted mid-transaction: on the next edge `req`=0, the state is IDLE and any pending response is discarded.

## Structure
- Shared package `dbus_init_pkg`:
  - `type_dbus_init_state_e` (IDLE/REQ/RESP).
  - `DBUS_INIT_TIMEOUT_DEFAULT` = 255.
  - `is_legal_sel_byte()` function.
- Bus structs come from the existing peripheral defs header; they are not redefined here.
- Single module; the timeout counter is inline and there is no sub-module.

## Test plan
- Read with ack in the cycle after `req`, `r_data`=0x0000_A5A5:
  - `rsp_rdata_o`=0x0000_A5A5, err=0.
  - `req` high for exactly 2 cycles; `rsp_valid_o` 3 cycles after accept.
- Write addr=0x04, wdata=0x1234, sel=0011:
  - One `req` pulse with `w_en`=1, `sel_byte`=0011.
  - Response rdata=0, err=0.
- No ack, `TIMEOUT_CYCLES`=8:
  - `req` high for 8 cycles, then response with err=1 and rdata=0.
  - An ack injected 2 cycles later is ignored and the state stays IDLE.
- sel_byte=0101: no `req` ever; response the next cycle with err=1.
- Response backpressure: `rsp_ready_i`=0 for 5 cycles.
  - `rsp_valid_o`, `rsp_rdata_o` and `rsp_err_o` stay stable; `cmd_ready_o`=0 throughout.
  - The next command is accepted one cycle after the handshake.
- `rst_n`=0 in the middle of REQ: `req`, `busy_o` and `rsp_valid_o` are 0 on the next edge, and a fresh read then completes normally.
